// File: rtl/ex_mem_pkg.sv
// Shared core constants (mirror of define.v) used by the ex/mem pipeline register.
package ex_mem_pkg;
   localparam logic       RstEnable    = 1'b1;
   localparam logic       WriteDisable = 1'b0;
   localparam logic       Stop         = 1'b1;
   localparam logic       NoStop       = 1'b0;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
   localparam int         RegBus       = 32;
   localparam int         RegAddrBus   = 5;
   localparam int         AluOpBus     = 8;
   localparam int         DoubleRegBus = 64;

   typedef enum logic [1:0] {
      PR_ADVANCE = 2'd0,
      PR_BUBBLE  = 2'd1,
      PR_HOLD    = 2'd2
   } pr_mode_e;

   // Decode the ex/mem stall pair; the non-monotonic combination falls back to hold.
   function automatic pr_mode_e pr_mode(input logic ex_stop, input logic mem_stop);
      if (ex_stop == Stop && mem_stop == NoStop)   return PR_BUBBLE;
      if (ex_stop == NoStop && mem_stop == NoStop) return PR_ADVANCE;
      return PR_HOLD;
   endfunction
endpackage

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/flush handling, MADD intermediate loop-back
// and a saturating bubble counter.
module ex_mem
   import ex_mem_pkg::*;
#(
   parameter int DATA_W   = RegBus,
   parameter int ADDR_W   = RegAddrBus,
   parameter int ALUOP_W  = AluOpBus,
   parameter int BUBCNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            stall,
   input  logic                  flush,
   input  logic [ADDR_W-1:0]     ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic [ALUOP_W-1:0]    ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_reg2,
   input  logic [2*DATA_W-1:0]   hilo_i,
   input  logic [1:0]            cnt_i,
   output logic [ADDR_W-1:0]     mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [ALUOP_W-1:0]    mem_aluop,
   output logic [DATA_W-1:0]     mem_mem_addr,
   output logic [DATA_W-1:0]     mem_reg2,
   output logic [2*DATA_W-1:0]   hilo_o,
   output logic [1:0]            cnt_o,
   output logic [BUBCNT_W-1:0]   bubble_cnt
);
   localparam logic [BUBCNT_W-1:0] BubOne = {{(BUBCNT_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0]   wd_q,     wd_d;
   logic                wreg_q,   wreg_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic [ALUOP_W-1:0]  aluop_q,  aluop_d;
   logic [DATA_W-1:0]   addr_q,   addr_d;
   logic [DATA_W-1:0]   reg2_q,   reg2_d;
   logic [2*DATA_W-1:0] hilo_q,   hilo_d;
   logic [1:0]          cnt_q,    cnt_d;
   logic [BUBCNT_W-1:0] bub_q,    bub_d;

   pr_mode_e mode;
   logic     unused_stall;

   assign unused_stall = ^{stall[5], stall[2:0]};
   assign mode         = pr_mode(stall[3], stall[4]);

   always_comb begin
      wd_d    = wd_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      aluop_d = aluop_q;
      addr_d  = addr_q;
      reg2_d  = reg2_q;
      hilo_d  = hilo_q;
      cnt_d   = cnt_q;
      bub_d   = bub_q;
      if (flush) begin
         wd_d    = '0;
         wreg_d  = WriteDisable;
         wdata_d = '0;
         aluop_d = ALUOP_W'(EXE_NOP_OP);
         addr_d  = '0;
         reg2_d  = '0;
         hilo_d  = '0;
         cnt_d   = 2'b00;
      end else begin
         unique case (mode)
            PR_BUBBLE: begin
               // ex is stalled mid-MADD: send a bubble but keep its intermediate alive.
               wd_d    = '0;
               wreg_d  = WriteDisable;
               wdata_d = '0;
               aluop_d = ALUOP_W'(EXE_NOP_OP);
               addr_d  = '0;
               reg2_d  = '0;
               hilo_d  = hilo_i;
               cnt_d   = cnt_i;
               if (bub_q != '1) bub_d = bub_q + BubOne;
            end
            PR_ADVANCE: begin
               wd_d    = ex_wd;
               wreg_d  = ex_wreg;
               wdata_d = ex_wdata;
               aluop_d = ex_aluop;
               addr_d  = ex_mem_addr;
               reg2_d  = ex_reg2;
               hilo_d  = '0;
               cnt_d   = 2'b00;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         wd_q    <= '0;
         wreg_q  <= WriteDisable;
         wdata_q <= '0;
         aluop_q <= ALUOP_W'(EXE_NOP_OP);
         addr_q  <= '0;
         reg2_q  <= '0;
         hilo_q  <= '0;
         cnt_q   <= 2'b00;
         bub_q   <= '0;
      end else begin
         wd_q    <= wd_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         aluop_q <= aluop_d;
         addr_q  <= addr_d;
         reg2_q  <= reg2_d;
         hilo_q  <= hilo_d;
         cnt_q   <= cnt_d;
         bub_q   <= bub_d;
      end
   end

   assign mem_wd       = wd_q;
   assign mem_wreg     = wreg_q;
   assign mem_wdata    = wdata_q;
   assign mem_aluop    = aluop_q;
   assign mem_mem_addr = addr_q;
   assign mem_reg2     = reg2_q;
   assign hilo_o       = hilo_q;
   assign cnt_o        = cnt_q;
   assign bubble_cnt   = bub_q;
endmodule
